rv32_wb_arbiter: RTL and testbench

- Writeback-side driver for the RV32IM integer register file write port.
- Merges single-cycle ALU results and variable-latency MUL/DIV (MDU) results into one registered write stream (wreg/wr/wd).
- Buffers MDU results in a small FIFO and exports a pending-destination mask for issue-stage hazard checks.
- Includes an anti-starvation stall so buffered MDU results always drain.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/rv32_wb_fifo.sv | 56 +++++
 rtl/rv32_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rv32_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the writeback record type used by the
// register-file write path.
package rv32_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_rec_t;

   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] m;
      m     = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rv32_wb_fifo.sv
// Synchronous FIFO for buffered MDU writeback records; exposes per-entry
// valid bits and contents so the owner can build a pending-destination mask.
module rv32_wb_fifo
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  wb_rec_t                  din,
   output wb_rec_t                  dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DEPTH-1:0]         vld,
   output wb_rec_t [DEPTH-1:0]      ents
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]          wptr_q, rptr_q;
   logic [DEPTH-1:0]     vld_q;
   wb_rec_t [DEPTH-1:0]  mem_q;
   logic                 do_push, do_pop;

   // Extra MSB on each pointer distinguishes full from empty when the indices match.
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count   = wptr_q - rptr_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rptr_q[AW-1:0]];
   assign vld     = vld_q;
   assign ents    = mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         vld_q  <= '0;
      end else begin
         if (do_pop) begin
            rptr_q                 <= rptr_q + 1'b1;
            vld_q[rptr_q[AW-1:0]]  <= 1'b0;
         end
         if (do_push) begin
            wptr_q                 <= wptr_q + 1'b1;
            vld_q[wptr_q[AW-1:0]]  <= 1'b1;
            mem_q[wptr_q[AW-1:0]]  <= din;
         end
      end
   end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write port driver: ALU results win by default, buffered MDU
// results drain in order, and a starvation stall forces the buffer to empty.
module rv32_wb_arbiter
   import rv32_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   input  logic [REG_ADDR_W-1:0]  alu_rd,
   input  logic [XLEN-1:0]        alu_data,
   output logic                   alu_stall,
   input  logic                   mdu_valid,
   output logic                   mdu_ready,
   input  logic [REG_ADDR_W-1:0]  mdu_rd,
   input  logic [XLEN-1:0]        mdu_data,
   output logic                   wreg,
   output logic [REG_ADDR_W-1:0]  wr,
   output logic [XLEN-1:0]        wd,
   output logic [NUM_REGS-1:0]    pend_mask,
   output logic                   proto_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [AW:0]                   fifo_count, occ_next;
   logic [FIFO_DEPTH-1:0]         fifo_vld;
   wb_rec_t [FIFO_DEPTH-1:0]      fifo_ents;
   wb_rec_t                       fifo_head, fifo_din;
   logic                          alu_win;

   logic                          wreg_q, stall_q, stall_d, proto_err_q;
   logic [REG_ADDR_W-1:0]         wr_q;
   logic [XLEN-1:0]               wd_q;
   logic [CW-1:0]                 starve_q, starve_d;

   assign alu_win   = !stall_q && alu_valid && (alu_rd != '0);
   assign fifo_pop  = !fifo_empty && !alu_win;
   assign fifo_push = mdu_valid && !fifo_full && (mdu_rd != '0);
   assign fifo_din  = '{rd: mdu_rd, data: mdu_data};
   assign mdu_ready = !fifo_full;

   rv32_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .vld   (fifo_vld),
      .ents  (fifo_ents)
   );

   always_comb begin
      pend_mask = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_vld[i]) pend_mask = pend_mask | rd_onehot(fifo_ents[i].rd);
      end
      pend_mask[0] = 1'b0;
   end

   always_comb begin
      occ_next = fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
      starve_d = starve_q;
      if (fifo_empty || fifo_pop) starve_d = '0;
      else if (starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
      // Release takes priority so a draining pop never re-arms the stall.
      stall_d = stall_q;
      if (fifo_empty || (fifo_pop && occ_next < (AW+1)'(FIFO_DEPTH / 2))) stall_d = 1'b0;
      else if (starve_q == CW'(STARVE_LIMIT)) stall_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wreg_q      <= 1'b0;
         wr_q        <= '0;
         wd_q        <= '0;
         stall_q     <= 1'b0;
         starve_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         wreg_q      <= alu_win || fifo_pop;
         stall_q     <= stall_d;
         starve_q    <= starve_d;
         proto_err_q <= proto_err_q || (alu_valid && stall_q);
         if (alu_win) begin
            wr_q <= alu_rd;
            wd_q <= alu_data;
         end else if (fifo_pop) begin
            wr_q <= fifo_head.rd;
            wd_q <= fifo_head.data;
         end
      end
   end

   assign wreg      = wreg_q;
   assign wr        = wr_q;
   assign wd        = wd_q;
   assign alu_stall = stall_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter: write-port scoreboard (exact-cycle ALU
// expectations, in-order MDU queue) plus explicit checks of flags and masks.
module tb_rv32_wb_arbiter;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mdu_valid, mdu_ready, alu_stall;
   logic [4:0]  alu_rd, mdu_rd, wr;
   logic [31:0] alu_data, mdu_data, wd, pend_mask;
   logic        wreg, proto_err;

   int          total = 0;
   int          bad   = 0;
   exp_t        mdu_q[$];
   logic        exp_alu = 1'b0;
   exp_t        exp_alu_w;

   always #5 clk = ~clk;

   rv32_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_stall (alu_stall),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_rd    (mdu_rd),
      .mdu_data  (mdu_data),
      .wreg      (wreg),
      .wr        (wr),
      .wd        (wd),
      .pend_mask (pend_mask),
      .proto_err (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d, input logic expect_wr);
      alu_valid = 1'b1;
      alu_rd    = rd;
      alu_data  = d;
      exp_alu   = expect_wr;
      exp_alu_w = '{rd: rd, d: d};
   endtask

   task automatic drive_mdu(input logic [4:0] rd, input logic [31:0] d, input logic enq);
      mdu_valid = 1'b1;
      mdu_rd    = rd;
      mdu_data  = d;
      chk("mdu_ready_pre", mdu_ready, 1);
      if (enq) mdu_q.push_back('{rd: rd, d: d});
   endtask

   // One clock: ordering rule check before the edge, write-port scoreboard after it.
   task automatic cyc();
      exp_t e;
      if (alu_valid && alu_rd != 5'd0) chk("order_pend", pend_mask[alu_rd], 0);
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
      mdu_valid = 1'b0;
      if (exp_alu) begin
         chk("alu_wreg", wreg, 1);
         chk("alu_wr", wr, exp_alu_w.rd);
         chk("alu_wd", wd, exp_alu_w.d);
      end else if (wreg) begin
         if (mdu_q.size() == 0) chk("unexpected_wreg", wreg, 0);
         else begin
            e = mdu_q.pop_front();
            chk("mdu_wr", wr, e.rd);
            chk("mdu_wd", wd, e.d);
         end
      end
      exp_alu = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; alu_valid = 1'b0; mdu_valid = 1'b0;
      alu_rd = '0; alu_data = '0; mdu_rd = '0; mdu_data = '0;
      cyc(); cyc();
      chk("rst_wreg", wreg, 0);
      chk("rst_wr", wr, 0);
      chk("rst_wd", wd, 0);
      chk("rst_stall", alu_stall, 0);
      chk("rst_proto", proto_err, 0);
      chk("rst_ready", mdu_ready, 1);
      chk("rst_pend", pend_mask, 0);
      rst = 1'b0;
      cyc();
      chk("idle_wreg", wreg, 0);

      // Single ALU write, then idle hold of wr/wd
      drive_alu(5'd5, 32'h0000_1234, 1'b1);
      cyc();
      cyc();
      chk("hold_wreg", wreg, 0);
      chk("hold_wr", wr, 5);
      chk("hold_wd", wd, 32'h0000_1234);

      // Lone MDU result: pending one cycle, written two edges after acceptance
      drive_mdu(5'd7, 32'hDEAD_BEEF, 1'b1);
      cyc();
      chk("mdu_pend", pend_mask, 32'h80);
      chk("mdu_wait_wreg", wreg, 0);
      cyc();
      chk("mdu_out_wreg", wreg, 1);
      chk("mdu_pend_clr", pend_mask, 0);

      // Two MDU results starved by ALU traffic until the stall kicks in
      for (int i = 0; i < 6; i++) begin
         drive_alu(5'(9 + i), 32'hA000 + 32'(i), 1'b1);
         if (i == 0) drive_mdu(5'd3, 32'h3333_0003, 1'b1);
         if (i == 1) drive_mdu(5'd4, 32'h4444_0004, 1'b1);
         cyc();
         if (i == 0) chk("starve_pend1", pend_mask, 32'h08);
         if (i == 1) begin
            chk("starve_full", mdu_ready, 0);
            chk("starve_pend2", pend_mask, 32'h18);
         end
         if (i == 4) chk("starve_nostall", alu_stall, 0);
      end
      chk("starve_stall", alu_stall, 1);
      cyc();
      chk("drain1_wr", wr, 3);
      chk("drain1_stall", alu_stall, 1);
      chk("drain1_pend", pend_mask, 32'h10);
      cyc();
      chk("drain2_wr", wr, 4);
      chk("drain2_stall", alu_stall, 0);
      chk("drain2_pend", pend_mask, 0);
      chk("drain2_ready", mdu_ready, 1);
      drive_alu(5'd15, 32'h0000_0F0F, 1'b1);
      cyc();

      // x0 destinations: no write, MDU handshake still completes
      drive_alu(5'd0, 32'h1111_1111, 1'b0);
      drive_mdu(5'd0, 32'h2222_2222, 1'b0);
      cyc();
      chk("x0_wreg", wreg, 0);
      chk("x0_pend", pend_mask, 0);
      chk("x0_ready", mdu_ready, 1);
      cyc();
      chk("x0_wreg2", wreg, 0);

      // ALU valid during stall: flagged, ignored, FIFO keeps draining
      for (int i = 0; i < 6; i++) begin
         drive_alu(5'(23 + i), 32'hB000 + 32'(i), 1'b1);
         if (i == 0) drive_mdu(5'd21, 32'h2121_2121, 1'b1);
         if (i == 1) drive_mdu(5'd22, 32'h2222_0022, 1'b1);
         cyc();
      end
      chk("perr_stall", alu_stall, 1);
      chk("perr_pre", proto_err, 0);
      drive_alu(5'd30, 32'hBAD0_BAD0, 1'b0);
      cyc();
      chk("perr_set", proto_err, 1);
      chk("perr_wr", wr, 21);
      cyc();
      chk("perr_wr2", wr, 22);
      cyc();
      chk("perr_sticky", proto_err, 1);
      chk("perr_idle", wreg, 0);

      // Reset with two buffered entries discards them
      drive_alu(5'd28, 32'hC000_0028, 1'b1);
      drive_mdu(5'd26, 32'h2626_2626, 1'b1);
      cyc();
      drive_alu(5'd29, 32'hC000_0029, 1'b1);
      drive_mdu(5'd27, 32'h2727_2727, 1'b1);
      cyc();
      chk("prerst_full", mdu_ready, 0);
      chk("prerst_pend", pend_mask, 32'h0C00_0000);
      mdu_q.delete();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_wreg", wreg, 0);
      chk("midrst_pend", pend_mask, 0);
      chk("midrst_ready", mdu_ready, 1);
      chk("midrst_proto", proto_err, 0);
      cyc();
      chk("postrst_wreg", wreg, 0);
      chk("sb_empty", mdu_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
